// File: rtl/multicycle_ctrl_seq.sv
// Multicycle CPU control sequencer: decodes OPCODE/FUNCT into op classes and walks fetch, decode,
// execute, memory, writeback, MULT/DIV busy and exception entry with parameterised latencies.
module multicycle_ctrl_seq #(
  parameter int unsigned MEM_WAIT    = 2,
  parameter int unsigned DEC_WAIT    = 2,
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned MD_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       O,
  input  logic       EG,
  input  logic       GT,
  input  logic       DIV0,
  output logic [3:0] state,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       hilo_write,
  output logic       md_start,
  output logic       epc_write,
  output logic [1:0] excp_code,
  output logic       reset_out
);

  typedef enum logic [3:0] {
    StReset = 4'd0, StFetchW, StFetchL, StDecode, StExec, StMemW, StWb,
    StJump, StMd, StExcp, StExcpW, StExcpL, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAluR, ClsAluI, ClsLoad, ClsStore, ClsBr, ClsJ, ClsJr, ClsMd, ClsBreak, ClsBad
  } cls_e;

  // Terminal counts; a zero wait still spends one cycle in its state.
  localparam logic [5:0] MemLast  = (MEM_WAIT == 0) ? 6'd0 : 6'(MEM_WAIT - 1);
  localparam logic [5:0] DecLast  = 6'(DEC_WAIT);
  localparam logic [5:0] ExecLast = (EXEC_CYCLES == 0) ? 6'd0 : 6'(EXEC_CYCLES - 1);
  localparam logic [5:0] MdLast   = 6'(MD_CYCLES);

  localparam logic [1:0] ExcpBadOp = 2'd0;
  localparam logic [1:0] ExcpOvf   = 2'd1;
  localparam logic [1:0] ExcpDiv0  = 2'd2;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  cls_e       cls_q, cls_d;
  logic [1:0] sub_q, sub_d;
  logic       ovf_q, ovf_d;
  logic [1:0] excp_q, excp_d;

  cls_e       dec_cls;
  logic [1:0] dec_sub;
  logic       dec_ovf;

  // sub carries the branch type, the JAL link flag or the DIV flag depending on class.
  always_comb begin
    dec_cls = ClsBad;
    dec_sub = 2'd0;
    dec_ovf = 1'b0;
    case (OPCODE)
      6'h00: begin
        case (FUNCT)
          6'h20, 6'h22: begin
            dec_cls = ClsAluR;
            dec_ovf = 1'b1;
          end
          6'h24, 6'h2a: dec_cls = ClsAluR;
          6'h08:        dec_cls = ClsJr;
          6'h18:        dec_cls = ClsMd;
          6'h1a: begin
            dec_cls = ClsMd;
            dec_sub = 2'd1;
          end
          6'h0d:        dec_cls = ClsBreak;
          default:      dec_cls = ClsBad;
        endcase
      end
      6'h08: begin
        dec_cls = ClsAluI;
        dec_ovf = 1'b1;
      end
      6'h09, 6'h0a:        dec_cls = ClsAluI;
      6'h20, 6'h21, 6'h23: dec_cls = ClsLoad;
      6'h28, 6'h29, 6'h2b: dec_cls = ClsStore;
      6'h04, 6'h05, 6'h06, 6'h07: begin
        dec_cls = ClsBr;
        dec_sub = OPCODE[1:0];
      end
      6'h02: dec_cls = ClsJ;
      6'h03: begin
        dec_cls = ClsJ;
        dec_sub = 2'd1;
      end
      default: dec_cls = ClsBad;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    sub_d        = sub_q;
    ovf_d        = ovf_q;
    excp_d       = excp_q;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    ir_write     = 1'b0;
    ab_write     = 1'b0;
    aluout_write = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    hilo_write   = 1'b0;
    md_start     = 1'b0;
    epc_write    = 1'b0;
    reset_out    = 1'b0;
    case (state_q)
      StReset: begin
        reset_out = 1'b1;
        reg_write = 1'b1;
        state_d   = StFetchW;
      end
      StFetchW: if (cnt_q == MemLast) state_d = StFetchL;
      StFetchL: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        if (cnt_q == DecLast) begin
          ab_write     = 1'b1;
          aluout_write = 1'b1;
          cls_d        = dec_cls;
          sub_d        = dec_sub;
          ovf_d        = dec_ovf;
          case (dec_cls)
            ClsJ, ClsJr: state_d = StJump;
            ClsMd:       state_d = StMd;
            ClsBreak:    state_d = StHalt;
            ClsBad: begin
              state_d = StExcp;
              excp_d  = ExcpBadOp;
            end
            default:     state_d = StExec;
          endcase
        end
      end
      StExec: begin
        if (cnt_q == ExecLast) begin
          aluout_write = 1'b1;
          case (cls_q)
            ClsAluR, ClsAluI: begin
              if (O && ovf_q) begin
                state_d = StExcp;
                excp_d  = ExcpOvf;
              end else begin
                state_d = StWb;
              end
            end
            ClsBr: begin
              pc_src = 2'd1;
              case (sub_q)
                2'd0:    pc_write = EG;
                2'd1:    pc_write = !EG;
                2'd2:    pc_write = !GT;
                default: pc_write = GT;
              endcase
              state_d = StFetchW;
            end
            ClsLoad: state_d = StMemW;
            ClsStore: begin
              mem_write = 1'b1;
              state_d   = StMemW;
            end
            default: state_d = StReset;
          endcase
        end
      end
      StMemW: if (cnt_q == MemLast) state_d = (cls_q == ClsLoad) ? StWb : StFetchW;
      StWb: begin
        reg_write = 1'b1;
        state_d   = StFetchW;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_src    = 2'd2;
        reg_write = (cls_q == ClsJ) && sub_q[0];
        state_d   = StFetchW;
      end
      StMd: begin
        md_start = (cnt_q == 6'd0);
        if (cnt_q == 6'd0 && sub_q[0] && DIV0) begin
          state_d = StExcp;
          excp_d  = ExcpDiv0;
        end else if (cnt_q == MdLast) begin
          hilo_write = 1'b1;
          state_d    = StFetchW;
        end
      end
      StExcp: begin
        epc_write = 1'b1;
        state_d   = StExcpW;
      end
      StExcpW: if (cnt_q == MemLast) state_d = StExcpL;
      StExcpL: begin
        pc_write = 1'b1;
        pc_src   = 2'd3;
        state_d  = StFetchW;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    if (state_d != state_q) cnt_d = 6'd0;
    else if (&cnt_q)        cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= StReset;
      cnt_q   <= 6'd0;
      cls_q   <= ClsBad;
      sub_q   <= 2'd0;
      ovf_q   <= 1'b0;
      excp_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      excp_q  <= excp_d;
    end
  end

  assign state     = state_q;
  assign excp_code = excp_q;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Bench for multicycle_ctrl_seq: directed and random instructions checked cycle by cycle against
// an expected-strobe timeline built from instruction class and latency arithmetic.
module tb_multicycle_ctrl_seq;

  localparam int unsigned MemWait    = 2;
  localparam int unsigned DecWait    = 2;
  localparam int unsigned ExecCycles = 2;
  localparam int unsigned MdCycles   = 32;

  // Expected-vector bit masks: {reset_out, pc_write, pc_src, ir_write, ab_write, aluout_write,
  // mem_write, reg_write, hilo_write, md_start, epc_write, excp_code}
  localparam logic [13:0] BRsto = 14'h2000;
  localparam logic [13:0] BPcw  = 14'h1000;
  localparam logic [13:0] Src1  = 14'h0400;
  localparam logic [13:0] Src2  = 14'h0800;
  localparam logic [13:0] Src3  = 14'h0c00;
  localparam logic [13:0] BIrw  = 14'h0200;
  localparam logic [13:0] BAbw  = 14'h0100;
  localparam logic [13:0] BAow  = 14'h0080;
  localparam logic [13:0] BMw   = 14'h0040;
  localparam logic [13:0] BRw   = 14'h0020;
  localparam logic [13:0] BHw   = 14'h0010;
  localparam logic [13:0] BMs   = 14'h0008;
  localparam logic [13:0] BEw   = 14'h0004;

  localparam int KAlu = 0, KLoad = 1, KStore = 2, KBr = 3, KJ = 4, KMd = 5, KBreak = 6, KBad = 7;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic [5:0] OPCODE = 6'd0, FUNCT = 6'd0;
  logic       O = 1'b0, EG = 1'b0, GT = 1'b0, DIV0 = 1'b0;
  logic [3:0] state;
  logic       pc_write, ir_write, ab_write, aluout_write, mem_write, reg_write;
  logic       hilo_write, md_start, epc_write, reset_out;
  logic [1:0] pc_src, excp_code;
  logic [13:0] obs;

  int n_checks = 0;
  int n_bad    = 0;
  logic [13:0] exp_q[$];
  logic [1:0]  exp_excp = 2'd0;
  logic [11:0] tab[26];

  multicycle_ctrl_seq #(
    .MEM_WAIT(MemWait), .DEC_WAIT(DecWait), .EXEC_CYCLES(ExecCycles), .MD_CYCLES(MdCycles)
  ) dut (
    .clk(clk), .reset_in(reset_in), .OPCODE(OPCODE), .FUNCT(FUNCT), .O(O), .EG(EG), .GT(GT),
    .DIV0(DIV0), .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .ab_write(ab_write), .aluout_write(aluout_write), .mem_write(mem_write),
    .reg_write(reg_write), .hilo_write(hilo_write), .md_start(md_start),
    .epc_write(epc_write), .excp_code(excp_code), .reset_out(reset_out)
  );

  always #5 clk = ~clk;

  assign obs = {reset_out, pc_write, pc_src, ir_write, ab_write, aluout_write, mem_write,
                reg_write, hilo_write, md_start, epc_write, excp_code};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%h want=%h", tag, $time, got, want);
    end
  endtask

  function automatic int classify(input logic [5:0] opc, input logic [5:0] fn);
    if (opc == 6'h00) begin
      if (fn inside {6'h20, 6'h22, 6'h24, 6'h2a}) return KAlu;
      if (fn == 6'h08) return KJ;
      if (fn inside {6'h18, 6'h1a}) return KMd;
      if (fn == 6'h0d) return KBreak;
      return KBad;
    end
    if (opc inside {6'h08, 6'h09, 6'h0a}) return KAlu;
    if (opc inside {6'h20, 6'h21, 6'h23}) return KLoad;
    if (opc inside {6'h28, 6'h29, 6'h2b}) return KStore;
    if (opc inside {6'h04, 6'h05, 6'h06, 6'h07}) return KBr;
    if (opc inside {6'h02, 6'h03}) return KJ;
    return KBad;
  endfunction

  task automatic push(input logic [13:0] m);
    exp_q.push_back(m | {12'd0, exp_excp});
  endtask

  task automatic model_excp(input logic [1:0] code);
    int mw;
    mw = (MemWait == 0) ? 1 : int'(MemWait);
    exp_excp = code;
    push(BEw);
    repeat (mw) push(14'd0);
    push(BPcw | Src3);
  endtask

  task automatic model_instr(input logic [5:0] opc, input logic [5:0] fn,
                             input bit o, input bit eg, input bit gt, input bit d0);
    int k, mw, ew;
    bit trap, taken, is_div;
    logic [13:0] last;
    mw     = (MemWait == 0) ? 1 : int'(MemWait);
    ew     = (ExecCycles == 0) ? 1 : int'(ExecCycles);
    k      = classify(opc, fn);
    trap   = (opc == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || opc == 6'h08;
    is_div = (opc == 6'h00 && fn == 6'h1a);
    case (opc)
      6'h04:   taken = eg;
      6'h05:   taken = !eg;
      6'h06:   taken = !gt;
      default: taken = gt;
    endcase
    repeat (mw) push(14'd0);
    push(BPcw | BIrw);
    repeat (DecWait) push(14'd0);
    push(BAbw | BAow);
    case (k)
      KBad:   model_excp(2'd0);
      KBreak: repeat (6) push(14'd0);
      KJ:     push(BPcw | Src2 | ((opc == 6'h03) ? BRw : 14'd0));
      KMd: begin
        push(BMs);
        if (is_div && d0) model_excp(2'd2);
        else begin
          repeat (MdCycles - 1) push(14'd0);
          push(BHw);
        end
      end
      default: begin
        repeat (ew - 1) push(14'd0);
        last = BAow;
        if (k == KBr) last = last | Src1 | (taken ? BPcw : 14'd0);
        if (k == KStore) last = last | BMw;
        push(last);
        if (k == KAlu) begin
          if (trap && o) model_excp(2'd1);
          else push(BRw);
        end else if (k == KLoad) begin
          repeat (mw) push(14'd0);
          push(BRw);
        end else if (k == KStore) begin
          repeat (mw) push(14'd0);
        end
      end
    endcase
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_val(tag, {18'd0, obs}, {18'd0, exp_q.pop_front()});
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                           input bit o, input bit eg, input bit gt, input bit d0);
    OPCODE = opc;
    FUNCT  = fn;
    O      = o;
    EG     = eg;
    GT     = gt;
    DIV0   = d0;
    model_instr(opc, fn, o, eg, gt, d0);
    drain(tag);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    exp_excp = 2'd0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_val("reset", {18'd0, obs}, {18'd0, BRsto | BRw});
    end
    reset_in = 1'b0;
  endtask

  initial begin
    int idx;
    logic [5:0] opc, fn;
    tab = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h2a}, {6'h08, 6'h00},
            {6'h09, 6'h00}, {6'h0a, 6'h00}, {6'h20, 6'h00}, {6'h21, 6'h00}, {6'h23, 6'h00},
            {6'h28, 6'h00}, {6'h29, 6'h00}, {6'h2b, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00},
            {6'h06, 6'h00}, {6'h07, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h00, 6'h08},
            {6'h00, 6'h18}, {6'h00, 6'h1a}, {6'h3f, 6'h00}, {6'h00, 6'h3f}, {6'h10, 6'h00},
            {6'h00, 6'h01}};
    #2;
    do_reset();

    run_instr("add",       6'h00, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("add_ovf",   6'h00, 6'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr("addiu_o",   6'h09, 6'h15, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr("beq_t",     6'h04, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("beq_nt",    6'h04, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr("div",       6'h00, 6'h1a, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("div0",      6'h00, 6'h1a, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr("bad_op",    6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("mult_d0",   6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b1);
    run_instr("jal",       6'h03, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("sw",        6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("lw",        6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      idx = int'($urandom_range(0, 25));
      opc = tab[idx][11:6];
      fn  = (opc == 6'h00) ? tab[idx][5:0] : 6'($urandom);
      run_instr("rand", opc, fn, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    run_instr("break", 6'h00, 6'h0d, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Abort MULT on its md_start cycle; strobes must drop without waiting for an edge.
    OPCODE = 6'h00;
    FUNCT  = 6'h18;
    DIV0   = 1'b0;
    model_instr(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (MemWait + DecWait + 3) begin
      @(negedge clk);
      check_val("mult_pre", {18'd0, obs}, {18'd0, exp_q.pop_front()});
    end
    #2 reset_in = 1'b1;
    exp_excp = 2'd0;
    exp_q.delete();
    #1 check_val("async_rst", {18'd0, obs}, {18'd0, BRsto | BRw});
    do_reset();
    run_instr("add_post", 6'h00, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
